// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Instruction-fetch PC sequencer placed directly in front of the branch
// predictor. Every cycle the current PC is presented to the predictor, whose
// combinational answer selects the next PC. Each issued instruction's
// {pc, predicted next pc} pair is kept in an in-order queue until execute
// resolves it; a resolution that disagrees with the prediction redirects the
// PC, empties the queue and pulses flush. Every resolved branch produces a
// one-cycle registered update on the predictor feedback port.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   bp_pc               current PC driven to the predictor lookup
//   bp_opinion          predictor holds a valid entry for bp_pc
//   bp_taken, bp_addr   predicted direction and target
//   imem_ready          instruction memory accepts pc this cycle
//   stall               decode backpressure
//   fetch_fire          instruction at fetch_pc issued this cycle
//   fetch_pc            PC of the issued instruction
//   fetch_pred_next     predicted next PC tagged onto the issued instruction
//   res_valid           execute resolves the oldest in-flight instruction
//   res_is_branch       resolved instruction is a conditional branch/jump
//   res_taken           actual direction (0 for non-branches)
//   res_target          actual target when taken
//   flush               registered one-cycle squash of all younger work
//   fb_enable, fb_taken, fb_branch_addr, fb_current_pc
//                       registered predictor update for a resolved branch
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
   parameter int unsigned           ADDR_SIZE = 32,
   parameter logic [ADDR_SIZE-1:0]  RESET_PC  = 32'h0040_0000,
   parameter int unsigned           QLOG      = 2
) (
   input  logic                  clk,
   input  logic                  reset,

   output logic [ADDR_SIZE-1:0]  bp_pc,
   input  logic                  bp_opinion,
   input  logic                  bp_taken,
   input  logic [ADDR_SIZE-1:0]  bp_addr,

   input  logic                  imem_ready,
   input  logic                  stall,
   output logic                  fetch_fire,
   output logic [ADDR_SIZE-1:0]  fetch_pc,
   output logic [ADDR_SIZE-1:0]  fetch_pred_next,

   input  logic                  res_valid,
   input  logic                  res_is_branch,
   input  logic                  res_taken,
   input  logic [ADDR_SIZE-1:0]  res_target,

   output logic                  flush,
   output logic                  fb_enable,
   output logic                  fb_taken,
   output logic [ADDR_SIZE-1:0]  fb_branch_addr,
   output logic [ADDR_SIZE-1:0]  fb_current_pc
);

   localparam int unsigned          QDEPTH  = 1 << QLOG;
   localparam logic [ADDR_SIZE-1:0] PC_STEP = ADDR_SIZE'(4);
   localparam logic [QLOG:0]        CNT_MAX = (QLOG+1)'(QDEPTH);

   logic [ADDR_SIZE-1:0] pc;
   logic [ADDR_SIZE-1:0] pred_next;

   // In-flight queue: circular buffer addressed by head/tail, occupancy in count.
   logic [ADDR_SIZE-1:0] q_pc   [QDEPTH];
   logic [ADDR_SIZE-1:0] q_pred [QDEPTH];
   logic [QLOG-1:0]      head;
   logic [QLOG-1:0]      tail;
   logic [QLOG:0]        count;
   logic [QLOG:0]        count_next;
   logic                 q_full;
   logic                 q_empty;

   logic [ADDR_SIZE-1:0] head_pc;
   logic [ADDR_SIZE-1:0] head_pred;
   logic [ADDR_SIZE-1:0] actual_next;
   logic                 res_hit;
   logic                 mispredict;
   logic                 do_deq;

   // ---------------------------------------------------------------------------
   // Prediction and issue
   // ---------------------------------------------------------------------------
   assign pred_next = (bp_opinion && bp_taken) ? bp_addr : pc + PC_STEP;

   assign q_full  = (count == CNT_MAX);
   assign q_empty = (count == '0);

   assign fetch_fire      = imem_ready && !stall && !q_full && !mispredict && !reset;
   assign bp_pc           = pc;
   assign fetch_pc        = pc;
   assign fetch_pred_next = pred_next;

   // ---------------------------------------------------------------------------
   // Resolution against the queue head
   // ---------------------------------------------------------------------------
   assign head_pc     = q_pc[head];
   assign head_pred   = q_pred[head];
   assign res_hit     = res_valid && !q_empty;
   assign actual_next = res_taken ? res_target : head_pc + PC_STEP;
   assign mispredict  = res_hit && (actual_next != head_pred);
   assign do_deq      = res_hit && !mispredict;

   // Simultaneous enqueue and dequeue leave occupancy unchanged.
   always_comb begin
      // NOTE: every variable assigned in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      count_next = count;
      case ({fetch_fire, do_deq})
         2'b10:   count_next = count + (QLOG+1)'(1);
         2'b01:   count_next = count - (QLOG+1)'(1);
         default: count_next = count;
      endcase
   end

   // Queue storage. Entries are only meaningful while counted, so the array
   // carries no reset. fetch_fire already excludes reset and mispredict cycles.
   // NOTE: storage arrays are deliberately left out of reset; validity is
   // tracked by count, and resetting the array would only add logic.
   always_ff @(posedge clk) begin
      if (fetch_fire) begin
         q_pc[tail]   <= pc;
         q_pred[tail] <= pred_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Control state: pc, queue pointers, flush and predictor feedback
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc             <= RESET_PC;
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         flush          <= 1'b0;
         fb_enable      <= 1'b0;
         fb_taken       <= 1'b0;
         fb_branch_addr <= '0;
         fb_current_pc  <= '0;
      end else begin
         flush     <= mispredict;
         fb_enable <= res_hit && res_is_branch;
         if (res_hit && res_is_branch) begin
            fb_taken       <= res_taken;
            fb_branch_addr <= res_target;
            fb_current_pc  <= head_pc;
         end

         if (mispredict) begin
            // Everything in flight is younger than the wrong prediction.
            pc    <= actual_next;
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (fetch_fire) begin
               pc   <= pred_next;
               tail <= tail + QLOG'(1);
            end
            if (do_deq) begin
               head <= head + QLOG'(1);
            end
            count <= count_next;
         end
      end
   end

endmodule
